// File: rtl/nzcv_cond_unit.sv
// nzcv_cond_unit: architectural NZCV flag register, DEPTH-entry shadow flag stack for
// exception entry/return, and NUM_PORTS independent ARMv4 condition evaluators with a
// one-cycle registered pass/fail result.
//
// Build option: define NZCV_BYPASS_EN to evaluate conditions against the flag register's
// next value (same-cycle s_input writes and accepted restores are visible). Without it,
// conditions see the registered flags of the current cycle.
module nzcv_cond_unit #(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned DEPTH     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [3:0]                   nzcv_input,
    input  logic                         s_input,
    input  logic                         save_input,
    input  logic                         restore_input,
    input  logic                         err_clear_input,
    input  logic [NUM_PORTS-1:0]         cond_valid_input,
    input  logic [4*NUM_PORTS-1:0]       opcode_input,
    output logic [NUM_PORTS-1:0]         operate,
    output logic [NUM_PORTS-1:0]         operate_valid,
    output logic [3:0]                   nzcv_output,
    output logic [$clog2(DEPTH+1)-1:0]   depth_output,
    output logic                         overflow_err,
    output logic                         underflow_err
);

    localparam int unsigned DW = $clog2(DEPTH + 1);

    // ARMv4 condition decode; flags are {N, Z, C, V}. 1111 is the never-pass NV code.
    function automatic logic cond_pass(input logic [3:0] op, input logic [3:0] f);
        logic n, z, c, v;
        logic res;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        unique case (op)
            4'b0000: res = z;
            4'b0001: res = ~z;
            4'b0010: res = c;
            4'b0011: res = ~c;
            4'b0100: res = n;
            4'b0101: res = ~n;
            4'b0110: res = v;
            4'b0111: res = ~v;
            4'b1000: res = c & ~z;
            4'b1001: res = ~c | z;
            4'b1010: res = ~(n ^ v);
            4'b1011: res = n ^ v;
            4'b1100: res = ~z & ~(n ^ v);
            4'b1101: res = z | (n ^ v);
            4'b1110: res = 1'b1;
            4'b1111: res = 1'b0;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    logic [3:0]           flags_q, flags_d;
    logic [DW-1:0]        depth_q, depth_d;
    logic [3:0]           stack_q [DEPTH];
    logic [3:0]           stack_d [DEPTH];
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;
    logic [NUM_PORTS-1:0] operate_q, operate_d;
    logic [NUM_PORTS-1:0] operate_valid_q, operate_valid_d;

    logic [DW-1:0]        top_idx;
    logic [3:0]           top_val;
    logic                 stack_full;
    logic                 stack_empty;
    logic                 restore_ok;
    logic                 ovf_set;
    logic                 unf_set;
    logic [3:0]           eval_flags;

    // Flag register, shadow stack and sticky error next-state.
    always_comb begin
        flags_d     = flags_q;
        depth_d     = depth_q;
        stack_d     = stack_q;
        restore_ok  = 1'b0;
        ovf_set     = 1'b0;
        unf_set     = 1'b0;
        stack_full  = (depth_q == DW'(DEPTH));
        stack_empty = (depth_q == '0);
        // Wraps to all-ones when empty, which never matches a real entry index.
        top_idx     = depth_q - DW'(1);
        top_val     = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (DW'(i) == top_idx) begin
                top_val = stack_q[i];
            end
        end

        if (save_input && restore_input) begin
            if (!stack_empty) begin
                // Swap: current flags replace the top entry, top entry becomes the flags.
                for (int i = 0; i < int'(DEPTH); i++) begin
                    if (DW'(i) == top_idx) begin
                        stack_d[i] = flags_q;
                    end
                end
                restore_ok = 1'b1;
            end else begin
                // Nothing to restore: the push still happens, the pop is flagged.
                stack_d[0] = flags_q;
                depth_d    = DW'(1);
                unf_set    = 1'b1;
            end
        end else if (save_input) begin
            if (!stack_full) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    if (DW'(i) == depth_q) begin
                        stack_d[i] = flags_q;
                    end
                end
                depth_d = depth_q + DW'(1);
            end else begin
                ovf_set = 1'b1;
            end
        end else if (restore_input) begin
            if (!stack_empty) begin
                restore_ok = 1'b1;
                depth_d    = top_idx;
            end else begin
                unf_set = 1'b1;
            end
        end

        // Accepted restore outranks an ALU write in the same cycle.
        if (restore_ok) begin
            flags_d = top_val;
        end else if (s_input) begin
            flags_d = nzcv_input;
        end

        // A new error in the clearing cycle keeps the bit set.
        ovf_d = ovf_set | (ovf_q & ~err_clear_input);
        unf_d = unf_set | (unf_q & ~err_clear_input);
    end

    // Per-port condition evaluation against the selected flag source.
    always_comb begin
`ifdef NZCV_BYPASS_EN
        eval_flags = flags_d;
`else
        eval_flags = flags_q;
`endif
        operate_d       = '0;
        operate_valid_d = cond_valid_input;
        for (int p = 0; p < int'(NUM_PORTS); p++) begin
            operate_d[p] = cond_valid_input[p] & cond_pass(opcode_input[4*p +: 4], eval_flags);
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q         <= '0;
            depth_q         <= '0;
            ovf_q           <= 1'b0;
            unf_q           <= 1'b0;
            operate_q       <= '0;
            operate_valid_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            flags_q         <= flags_d;
            depth_q         <= depth_d;
            ovf_q           <= ovf_d;
            unf_q           <= unf_d;
            operate_q       <= operate_d;
            operate_valid_q <= operate_valid_d;
            for (int i = 0; i < int'(DEPTH); i++) begin
                stack_q[i] <= stack_d[i];
            end
        end
    end

    assign operate       = operate_q;
    assign operate_valid = operate_valid_q;
    assign nzcv_output   = flags_q;
    assign depth_output  = depth_q;
    assign overflow_err  = ovf_q;
    assign underflow_err = unf_q;

endmodule

// File: tb/tb_nzcv_cond_unit.sv
// Self-checking bench for nzcv_cond_unit: directed scenarios plus randomized traffic
// compared against a queue-based behavioural model of flags, shadow stack and conditions.
module tb_nzcv_cond_unit;

    localparam int NP = 2;
    localparam int D  = 4;
    localparam int DW = $clog2(D + 1);
`ifdef NZCV_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif
    localparam int OW = 2 * NP + 4 + DW + 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        nzcv_input;
    logic              s_input;
    logic              save_input;
    logic              restore_input;
    logic              err_clear_input;
    logic [NP-1:0]     cond_valid_input;
    logic [4*NP-1:0]   opcode_input;
    logic [NP-1:0]     operate;
    logic [NP-1:0]     operate_valid;
    logic [3:0]        nzcv_output;
    logic [DW-1:0]     depth_output;
    logic              overflow_err;
    logic              underflow_err;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    logic [3:0]    m_flags;
    logic [3:0]    m_stk [$];
    logic          m_ovf;
    logic          m_unf;
    logic [NP-1:0] m_op;
    logic [NP-1:0] m_opv;

    nzcv_cond_unit #(
        .NUM_PORTS(NP),
        .DEPTH    (D)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .nzcv_input      (nzcv_input),
        .s_input         (s_input),
        .save_input      (save_input),
        .restore_input   (restore_input),
        .err_clear_input (err_clear_input),
        .cond_valid_input(cond_valid_input),
        .opcode_input    (opcode_input),
        .operate         (operate),
        .operate_valid   (operate_valid),
        .nzcv_output     (nzcv_output),
        .depth_output    (depth_output),
        .overflow_err    (overflow_err),
        .underflow_err   (underflow_err)
    );

    always #5 clk = ~clk;

    wire [OW-1:0] obs_all = {operate, operate_valid, nzcv_output, depth_output,
                             overflow_err, underflow_err};

    // Architectural meaning: even codes test a predicate, odd codes its negation; 1111 never.
    function automatic logic ref_cond(input logic [3:0] op, input logic [3:0] f);
        bit n, z, c, v, base;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (op[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (op == 4'hF) return 1'b0;
        return base ^ op[0];
    endfunction

    function automatic logic [OW-1:0] exp_all();
        return {m_op, m_opv, m_flags, DW'(m_stk.size()), m_ovf, m_unf};
    endfunction

    task automatic model_reset();
        m_flags = '0;
        m_stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_op  = '0;
        m_opv = '0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        logic [3:0] old_f;
        logic [3:0] ev;
        int n;
        bit acc, nov, nun;
        old_f = m_flags;
        n = m_stk.size();
        acc = 0; nov = 0; nun = 0;
        if (save_input && restore_input) begin
            if (n > 0) begin
                m_flags = m_stk[n-1];
                m_stk[n-1] = old_f;
                acc = 1;
            end else begin
                m_stk.push_back(old_f);
                nun = 1;
            end
        end else if (save_input) begin
            if (n < D) m_stk.push_back(old_f);
            else nov = 1;
        end else if (restore_input) begin
            if (n > 0) begin
                m_flags = m_stk.pop_back();
                acc = 1;
            end else begin
                nun = 1;
            end
        end
        if (!acc && s_input) m_flags = nzcv_input;
        if (err_clear_input) begin
            m_ovf = 0;
            m_unf = 0;
        end
        if (nov) m_ovf = 1;
        if (nun) m_unf = 1;
        ev = BYPASS ? m_flags : old_f;
        for (int p = 0; p < NP; p++) begin
            m_op[p] = cond_valid_input[p] && ref_cond(opcode_input[4*p +: 4], ev);
        end
        m_opv = cond_valid_input;
    endtask

    task automatic idle_inputs();
        nzcv_input       = '0;
        s_input          = 1'b0;
        save_input       = 1'b0;
        restore_input    = 1'b0;
        err_clear_input  = 1'b0;
        cond_valid_input = '0;
        opcode_input     = '0;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        #2;
        checks++;
        if (obs_all !== '0) begin
            failures++;
            $display("FAIL reset_state: got %h want 0", obs_all);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_opcodes();
        logic [15:0] tab;
        tab = 16'h66A9;  // expected pass per opcode with Z set, N=C=V clear
        do_reset();
        s_input = 1'b1;
        nzcv_input = 4'b0100;
        step();
        s_input = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cond_valid_input = 2'b01;
            opcode_input = {4'hF, 4'(i)};
            step();
            checks++;
            if ({operate, operate_valid} !== {1'b0, tab[i], 2'b01}) begin
                failures++;
                $display("FAIL opcode_%0d: operate=%b valid=%b want operate[0]=%b valid=01",
                         i, operate, operate_valid, tab[i]);
            end
        end
        checks++;
        if (obs_all !== exp_all()) begin
            failures++;
            $display("FAIL opcode_model: got %h want %h", obs_all, exp_all());
        end
    endtask

    task automatic test_bypass();
        logic exp_mi;
        do_reset();
        s_input = 1'b1;
        nzcv_input = 4'b1000;
        cond_valid_input = 2'b10;
        opcode_input = {4'b0100, 4'b0000};
        step();
        exp_mi = BYPASS;
        checks++;
        if (operate[1] !== exp_mi || operate_valid !== 2'b10) begin
            failures++;
            $display("FAIL bypass_mi: operate=%b valid=%b want operate[1]=%b valid=10",
                     operate, operate_valid, exp_mi);
        end
        s_input = 1'b0;
        step();
        checks++;
        if (operate[1] !== 1'b1 || nzcv_output !== 4'b1000) begin
            failures++;
            $display("FAIL bypass_next: operate=%b nzcv=%b want operate[1]=1 nzcv=1000",
                     operate, nzcv_output);
        end
        idle_inputs();
        step();
        checks++;
        if (operate_valid !== 2'b00 || operate !== 2'b00) begin
            failures++;
            $display("FAIL single_cycle_result: operate=%b valid=%b want 00/00",
                     operate, operate_valid);
        end
    endtask

    task automatic test_stack_overflow();
        do_reset();
        s_input = 1'b1;
        nzcv_input = 4'd1;
        step();
        for (int k = 2; k <= 5; k++) begin
            save_input = 1'b1;
            nzcv_input = 4'(k);
            step();
        end
        s_input = 1'b0;
        step();  // fifth save, stack already full
        save_input = 1'b0;
        checks++;
        if (depth_output !== DW'(4) || overflow_err !== 1'b1 || nzcv_output !== 4'd5) begin
            failures++;
            $display("FAIL overflow: depth=%0d ovf=%b nzcv=%0d want depth=4 ovf=1 nzcv=5",
                     depth_output, overflow_err, nzcv_output);
        end
        for (int k = 4; k >= 1; k--) begin
            restore_input = 1'b1;
            step();
            checks++;
            if (nzcv_output !== 4'(k) || depth_output !== DW'(k - 1)) begin
                failures++;
                $display("FAIL restore_%0d: nzcv=%0d depth=%0d want nzcv=%0d depth=%0d",
                         k, nzcv_output, depth_output, k, k - 1);
            end
        end
        restore_input = 1'b0;
    endtask

    task automatic test_underflow();
        do_reset();
        restore_input = 1'b1;
        s_input = 1'b1;
        nzcv_input = 4'b0011;
        step();
        checks++;
        if ({nzcv_output, underflow_err, overflow_err, depth_output} !==
            {4'b0011, 1'b1, 1'b0, DW'(0)}) begin
            failures++;
            $display("FAIL underflow: nzcv=%b unf=%b ovf=%b depth=%0d want 0011 1 0 0",
                     nzcv_output, underflow_err, overflow_err, depth_output);
        end
        idle_inputs();
        err_clear_input = 1'b1;
        step();
        checks++;
        if (underflow_err !== 1'b0 || overflow_err !== 1'b0) begin
            failures++;
            $display("FAIL err_clear: unf=%b ovf=%b want 0 0", underflow_err, overflow_err);
        end
        restore_input = 1'b1;
        step();
        idle_inputs();
        checks++;
        if (underflow_err !== 1'b1) begin
            failures++;
            $display("FAIL err_set_wins: unf=%b want 1", underflow_err);
        end
    endtask

    task automatic test_swap();
        do_reset();
        s_input = 1'b1;
        nzcv_input = 4'b1010;
        step();
        save_input = 1'b1;
        nzcv_input = 4'b0101;
        step();
        checks++;
        if (nzcv_output !== 4'b0101 || depth_output !== DW'(1)) begin
            failures++;
            $display("FAIL swap_setup: nzcv=%b depth=%0d want 0101 1", nzcv_output, depth_output);
        end
        restore_input = 1'b1;
        nzcv_input = 4'b1111;
        step();
        checks++;
        if (nzcv_output !== 4'b1010 || depth_output !== DW'(1) || underflow_err !== 1'b0) begin
            failures++;
            $display("FAIL swap: nzcv=%b depth=%0d unf=%b want 1010 1 0",
                     nzcv_output, depth_output, underflow_err);
        end
        idle_inputs();
        restore_input = 1'b1;
        step();
        restore_input = 1'b0;
        checks++;
        if (nzcv_output !== 4'b0101 || depth_output !== DW'(0)) begin
            failures++;
            $display("FAIL swap_top: nzcv=%b depth=%0d want 0101 0", nzcv_output, depth_output);
        end
        // Save+restore on an empty stack: push happens and underflow is flagged.
        s_input = 1'b1;
        save_input = 1'b1;
        restore_input = 1'b1;
        nzcv_input = 4'b0110;
        step();
        idle_inputs();
        checks++;
        if ({nzcv_output, depth_output, underflow_err} !== {4'b0110, DW'(1), 1'b1}) begin
            failures++;
            $display("FAIL swap_empty: nzcv=%b depth=%0d unf=%b want 0110 1 1",
                     nzcv_output, depth_output, underflow_err);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            save_input = 1'b1;
            s_input = 1'b1;
            nzcv_input = 4'($urandom_range(1, 15));
            step();
        end
        idle_inputs();
        cond_valid_input = 2'b11;
        opcode_input = {4'b1110, 4'b1110};
        step();
        checks++;
        if (depth_output !== DW'(3) || operate_valid !== 2'b11 || operate !== 2'b11) begin
            failures++;
            $display("FAIL pre_reset: depth=%0d valid=%b operate=%b want 3 11 11",
                     depth_output, operate_valid, operate);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (obs_all !== '0) begin
            failures++;
            $display("FAIL async_reset: got %h want 0", obs_all);
        end
        idle_inputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        do_reset();
        for (int t = 0; t < 400; t++) begin
            nzcv_input       = 4'($urandom);
            s_input          = ($urandom_range(0, 1) == 1);
            save_input       = ($urandom_range(0, 9) < 3);
            restore_input    = ($urandom_range(0, 9) < 3);
            err_clear_input  = ($urandom_range(0, 19) == 0);
            cond_valid_input = NP'($urandom);
            opcode_input     = (4 * NP)'($urandom);
            step();
            checks++;
            if (obs_all !== exp_all()) begin
                failures++;
                $display("FAIL random_%0d: got %h want %h", t, obs_all, exp_all());
            end
        end
        idle_inputs();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_opcodes();
        test_bypass();
        test_stack_overflow();
        test_underflow();
        test_swap();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nzcv_cond_unit.md
# nzcv_cond_unit

Architectural NZCV flag register and multi-port ARMv4 condition evaluator for the execute stage. Holds the current flags and updates them from the ALU when the S bit is set. Keeps a DEPTH-entry shadow stack for exception entry and return. Evaluates up to NUM_PORTS 4-bit condition fields per cycle, each with a registered pass/fail result one cycle later.

## Interface
Parameters:
- NUM_PORTS, 2, number of independent condition-check ports (1..8)
- DEPTH, 4, shadow flag stack entries (1..16)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- nzcv_input  in  4  new flags from ALU; [3]=N [2]=Z [1]=C [0]=V
- s_input  in  1  write nzcv_input into flag register this cycle
- save_input  in  1  push current flag register onto shadow stack (exception entry)
- restore_input  in  1  pop shadow stack top into flag register (exception return)
- err_clear_input  in  1  clear both sticky error bits
- cond_valid_input  in  NUM_PORTS  per-port condition request valid
- opcode_input  in  4*NUM_PORTS  per-port condition field; port p at [4p+3:4p]
- operate  out  NUM_PORTS  registered per-port pass (1) / fail (0)
- operate_valid  out  NUM_PORTS  registered copy of cond_valid_input
- nzcv_output  out  4  current flag register
- depth_output  out  $clog2(DEPTH+1)  occupied shadow entries
- overflow_err  out  1  sticky: save attempted while full
- underflow_err  out  1  sticky: restore attempted while empty

## Operation
- Condition encoding (f = flags used for evaluation): 0000 Z; 0001 !Z; 0010 C; 0011 !C; 0100 N; 0101 !N; 0110 V; 0111 !V; 1000 C&!Z; 1001 !C|Z; 1010 N==V; 1011 N!=V; 1100 !Z&(N==V); 1101 Z|(N!=V); 1110 1; 1111 0 (ARMv4 NV).
- Flag register next-value priority: accepted restore > s_input > hold.
- save alone, depth<DEPTH: stack[depth] <= flags (pre-update value); depth+1. s_input in the same cycle still updates flags.
- save alone, depth==DEPTH: push dropped, depth held, overflow_err <= 1.
- restore alone, depth>0: flags <= stack[depth-1]; depth-1; s_input ignored.
- restore alone, depth==0: restore ignored, underflow_err <= 1, s_input applies normally.
- save and restore together, depth>0: swap. stack[depth-1] <= flags, flags <= old stack[depth-1], depth unchanged, s_input ignored.
- save and restore together, depth==0: push performed, depth becomes 1, underflow_err <= 1, s_input applies.
- Error bits are sticky until err_clear_input or rst. A new error in the same cycle as err_clear_input wins (bit set).
- Ports are fully independent. Ports without cond_valid_input hold operate at 0.

## Timing
- Reset (async): flags 4'b0000, depth 0, all stack entries 0, operate 0, operate_valid 0, both error bits 0. Any in-flight request is discarded.
- Flag, stack and error updates are visible on outputs the cycle after the triggering edge.
- Condition latency: request in cycle t -> operate/operate_valid valid in cycle t+1 for exactly one cycle. No stall and no backpressure; a new request is accepted every cycle on every port.
- Evaluation flag source in cycle t: see Configuration.

## Configuration
- NZCV_BYPASS_EN defined: evaluation in cycle t uses the flag register's next value. This includes same-cycle s_input writes and accepted restores. A compare and the dependent conditional instruction can issue back-to-back.
- NZCV_BYPASS_EN undefined: evaluation uses the registered flags (nzcv_output) of cycle t. Same-cycle updates are seen by requests from cycle t+1 onward.

## Test plan
- Reset, then all 16 opcodes on port 0 with flags set by s_input to 4'b0100 -> cycle t+1 operate: EQ=1, NE=0, LS=1, HI=0, GT=0, LE=1, AL=1, NV=0.
- Same-cycle s_input with nzcv_input=4'b1000 and opcode 0100 (MI) on port 1 -> operate[1]=1 with NZCV_BYPASS_EN; operate[1]=0 without it (flags previously 0).
- DEPTH=4: five saves with flags 1,2,3,4,5 -> depth_output=4, overflow_err=1. Then four restores -> nzcv_output 4,3,2,1 in successive cycles, depth 0.
- Restore at depth 0 together with s_input nzcv_input=4'b0011 -> flags=0011, underflow_err=1. Then err_clear_input -> both errors 0.
- Save and restore together at depth 1 (stack top=1010, flags=0101) -> flags=1010, top=0101, depth stays 1.
- Assert rst mid-stream with depth 3 and operate_valid high -> all outputs zero immediately, without waiting for a clock edge.
